// File: rtl/csr_trap_ctrl_if.sv
// rtl/csr_trap_ctrl_if.sv - WB/CSR/IF signal bundle for the CSR trap controller
interface csr_trap_ctrl_if #(
  parameter int CNT_W = 16
);
  logic              wb_valid;
  logic              wb_ready;
  logic [31:0]       wb_pc;
  logic              wb_ex;
  logic [5:0]        wb_ecode;
  logic [8:0]        wb_esubcode;
  logic [31:0]       wb_vaddr;
  logic              wb_ertn;
  logic [13:0]       wb_csr_num;
  logic              wb_csr_re;
  logic              wb_csr_we;
  logic [31:0]       wb_csr_wvalue;
  logic [31:0]       wb_csr_wmask;
  logic              has_int;
  logic [31:0]       ex_entry;
  logic [31:0]       era_pc;
  logic [79:0]       csr_ctrl;
  logic [80:0]       csr_commit;
  logic              flush;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              redirect_ready;
  logic [CNT_W-1:0]  trap_cnt;

  // Controller side
  modport slave (
    input  wb_valid, wb_pc, wb_ex, wb_ecode, wb_esubcode, wb_vaddr, wb_ertn,
           wb_csr_num, wb_csr_re, wb_csr_we, wb_csr_wvalue, wb_csr_wmask,
           has_int, ex_entry, era_pc, redirect_ready,
    output wb_ready, csr_ctrl, csr_commit, flush, redirect_valid, redirect_pc, trap_cnt
  );

  // Pipeline / CSR file / IF side
  modport master (
    output wb_valid, wb_pc, wb_ex, wb_ecode, wb_esubcode, wb_vaddr, wb_ertn,
           wb_csr_num, wb_csr_re, wb_csr_we, wb_csr_wvalue, wb_csr_wmask,
           has_int, ex_entry, era_pc, redirect_ready,
    input  wb_ready, csr_ctrl, csr_commit, flush, redirect_valid, redirect_pc, trap_cnt
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// rtl/csr_trap_ctrl.sv - sequences WB-stage CSR accesses, trap entry and ertn return
module csr_trap_ctrl #(
  parameter logic [5:0] ECODE_INT = 6'h00,
  parameter int         CNT_W     = 16
) (
  input  logic                clk,
  input  logic                resetn,
  csr_trap_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_REDIR  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic              r_is_trap;
  logic [5:0]        r_ecode;
  logic [8:0]        r_esubcode;
  logic [31:0]       r_pc;
  logic [31:0]       r_vaddr;
  logic [31:0]       r_redirect_pc;
  logic [CNT_W-1:0]  r_trap_cnt;

  logic              w_take_int;
  logic              w_take_ex;
  logic              w_take_ertn;
  logic              w_event;

  // Priority interrupt > exception > ertn; only a valid instruction can start an event
  assign w_take_int  = bus.wb_valid & bus.has_int;
  assign w_take_ex   = bus.wb_valid & ~bus.has_int & bus.wb_ex;
  assign w_take_ertn = bus.wb_valid & ~bus.has_int & ~bus.wb_ex & bus.wb_ertn;
  assign w_event     = w_take_int | w_take_ex | w_take_ertn;

  assign bus.redirect_pc = r_redirect_pc;
  assign bus.trap_cnt    = r_trap_cnt;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and per-state outputs; CSR access is suppressed whenever a trap/ertn is taken
  always_comb begin
    w_next             = r_state;
    bus.wb_ready       = 1'b0;
    bus.flush          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.csr_ctrl       = 80'h0;
    bus.csr_commit     = 81'h0;
    case (r_state)
      S_IDLE: begin
        bus.wb_ready = 1'b1;
        if (w_event) begin
          w_next = S_COMMIT;
        end else if (bus.wb_valid) begin
          bus.csr_ctrl = {bus.wb_csr_num, bus.wb_csr_re, bus.wb_csr_we,
                          bus.wb_csr_wvalue, bus.wb_csr_wmask};
        end
      end
      S_COMMIT: begin
        bus.flush = 1'b1;
        if (r_is_trap) begin
          bus.csr_commit = {1'b0, 1'b1, r_ecode, r_esubcode, r_pc, r_vaddr};
        end else begin
          bus.csr_commit = {1'b1, 80'h0};
        end
        w_next = S_REDIR;
      end
      S_REDIR: begin
        bus.flush          = 1'b1;
        bus.redirect_valid = 1'b1;
        if (bus.redirect_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Capture the event class and its commit fields when IDLE accepts a trap or ertn
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_is_trap  <= 1'b0;
      r_ecode    <= 6'h0;
      r_esubcode <= 9'h0;
      r_pc       <= 32'h0;
      r_vaddr    <= 32'h0;
    end else if (r_state == S_IDLE && w_event) begin
      r_is_trap <= w_take_int | w_take_ex;
      if (w_take_int) begin
        r_ecode    <= ECODE_INT;
        r_esubcode <= 9'h0;
        r_pc       <= bus.wb_pc;
        r_vaddr    <= 32'h0;
      end else if (w_take_ex) begin
        r_ecode    <= bus.wb_ecode;
        r_esubcode <= bus.wb_esubcode;
        r_pc       <= bus.wb_pc;
        r_vaddr    <= bus.wb_vaddr;
      end else begin
        r_ecode    <= 6'h0;
        r_esubcode <= 9'h0;
        r_pc       <= 32'h0;
        r_vaddr    <= 32'h0;
      end
    end
  end

  // Redirect target is sampled in COMMIT, before the CSR file applies the commit; counter saturates
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_redirect_pc <= 32'h0;
      r_trap_cnt    <= '0;
    end else if (r_state == S_COMMIT) begin
      r_redirect_pc <= r_is_trap ? bus.ex_entry : bus.era_pc;
      if (r_trap_cnt != {CNT_W{1'b1}}) begin
        r_trap_cnt <= r_trap_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
- Sequences every access to the CSR file from the writeback stage.
- Chooses, per retiring instruction, one of: normal CSR read/write, exception entry, interrupt entry, or ertn return.
- Drives the CSR commit bus for one cycle, asserts pipeline flush, and holds a fetch redirect until fetch accepts it.
- Sits between the WB stage, the CSR file and IF.

Parameters:
ECODE_INT, 6'h00, ecode written for interrupt entry
CNT_W, 16, width of saturating trap counter

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
wb_valid  in  1  instruction present in WB
wb_ready  out  1  WB instruction consumed this cycle
wb_pc  in  32  WB instruction PC
wb_ex  in  1  WB instruction carries exception
wb_ecode  in  6  exception code
wb_esubcode  in  9  exception subcode
wb_vaddr  in  32  faulting data address
wb_ertn  in  1  WB instruction is ertn
wb_csr_num  in  14  CSR number
wb_csr_re  in  1  CSR read request
wb_csr_we  in  1  CSR write request
wb_csr_wvalue  in  32  CSR write data
wb_csr_wmask  in  32  CSR write mask
has_int  in  1  pending enabled interrupt from CSR file
ex_entry  in  32  exception entry address from CSR file
era_pc  in  32  return address from CSR file
csr_ctrl  out  80  {num[13:0], re, we, wvalue[31:0], wmask[31:0]} to CSR file
csr_commit  out  81  {ertn_flush, ex, ecode[5:0], esubcode[8:0], pc[31:0], vaddr[31:0]} to CSR file
flush  out  1  kill all younger pipeline instructions
redirect_valid  out  1  redirect request to IF
redirect_pc  out  32  redirect target
redirect_ready  in  1  IF accepts redirect
trap_cnt  out  CNT_W  count of trap/ertn commits, saturating

Behaviour:
- States: IDLE, COMMIT, REDIR. Reset (resetn=0 at clk edge) forces IDLE from any state, including mid-trap.
- Reset values: all trap registers zero, trap_cnt=0, flush=0, redirect_valid=0, redirect_pc=0, csr_commit=0.
- wb_ready: 1 in IDLE, 0 in COMMIT and REDIR.
- IDLE, when wb_valid=1, classify with priority interrupt > exception > ertn > CSR access:
  - has_int=1: trap with ecode=ECODE_INT, esubcode=0, pc=wb_pc, vaddr=0.
  - else wb_ex=1: trap with wb_ecode, wb_esubcode, wb_pc, wb_vaddr.
  - else wb_ertn=1: return.
  - else: plain retire.
- Trap or return:
  - Latch class and fields; go to COMMIT next cycle.
  - csr_ctrl re/we forced 0 this cycle, so a faulting or interrupted CSR instruction never writes.
- Plain retire:
  - csr_ctrl = {wb_csr_num, wb_csr_re, wb_csr_we, wb_csr_wvalue, wb_csr_wmask}, combinational, zero latency.
  - Stay in IDLE.
- wb_valid=0 in IDLE: csr_ctrl all zero; has_int ignored. Interrupts are taken only on a valid instruction.
- COMMIT, exactly one cycle:
  - Trap: csr_commit.ex=1 with the latched fields.
  - Return: csr_commit.ertn_flush=1, all other fields 0.
  - csr_ctrl all zero; flush=1.
  - redirect_pc loads ex_entry (trap) or era_pc (return), sampled this cycle, before the CSR file updates.
  - trap_cnt increments unless already all-ones.
  - Next state REDIR.
- REDIR:
  - flush=1, redirect_valid=1, redirect_pc held stable.
  - csr_commit all zero; has_int and wb_* ignored.
  - Return to IDLE on the cycle redirect_ready=1; redirect_valid and flush drop the following cycle.
- Minimum trap occupancy is 2 cycles (COMMIT plus one REDIR with redirect_ready=1). No upper bound; REDIR waits indefinitely.
- Outside COMMIT, csr_commit is all zero.
- trap_cnt holds at all-ones once it saturates (CNT_W bits, no wrap).

Test Plan:
- Plain write: IDLE, wb_valid=1, csr_we=1, num=0x30, wvalue=0xDEADBEEF, wmask=0xFFFFFFFF -> csr_ctrl reflects these the same cycle; wb_ready=1; no flush.
- Exception: wb_ex=1, ecode=0x0B, pc=0x1C000100, ex_entry=0x1C008000 -> next cycle csr_commit.ex=1 with ecode 0x0B and pc 0x1C000100, flush=1. Following cycle redirect_valid=1, redirect_pc=0x1C008000. redirect_ready=1 -> IDLE. trap_cnt=1.
- Interrupt masks CSR write: has_int=1, wb_ex=1, csr_we=1 -> csr_ctrl.we=0; commit ecode=0x00, esubcode=0.
- ertn: wb_ertn=1, era_pc=0x1C000204 -> COMMIT drives ertn_flush=1, ex=0; redirect_pc=0x1C000204.
- Stalled redirect: redirect_ready low 5 cycles -> redirect_valid, flush and redirect_pc stable, wb_ready=0 throughout. has_int pulse during REDIR is ignored.
- Reset in REDIR: resetn=0 one cycle -> IDLE; redirect_valid=0, flush=0, trap_cnt=0 next cycle. Separately, preload trap_cnt=0xFFFF and take one trap -> stays 0xFFFF.
